// File: rtl/pipe_ctrl.sv
// +--------------------------------------------------------------------------+
// | pipe_ctrl : stall/flush/redirect control for the five-stage NPC pipeline  |
// | Optional build macro: PIPE_CTRL_PERF_EN (stall/flush cycle counters)      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module pipe_ctrl #(
  parameter int FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_load_hazard_i,
  input  logic        if_busy_i,
  input  logic        mem_busy_i,
  input  logic        ex_jump_i,
  input  logic [63:0] ex_jump_addr_i,
  input  logic        ex_muldiv_start_i,
  input  logic        ex_muldiv_done_i,
  output logic [4:0]  stall_o,
  output logic [2:0]  flush_o,
  output logic        jump_o,
  output logic [63:0] jump_addr_o,
  output logic [1:0]  ctrl_state_o,
  output logic [31:0] stall_cycles_o,
  output logic [31:0] flush_cycles_o
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MD_WAIT = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_BAD     = 2'd3
  } state_t;

  localparam logic [1:0] C_FCNT_LOAD   = 2'(FLUSH_CYCLES - 1);
  localparam bit         C_MULTI_FLUSH = (FLUSH_CYCLES > 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_fcnt;
  logic [1:0] w_fcnt_nxt;
  logic [4:0] w_stall;
  logic [2:0] w_flush;
  logic       w_jump;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_fcnt  <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    w_stall     = 5'b00000;
    w_flush     = 3'b000;
    w_jump      = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (mem_busy_i) begin
          w_stall = 5'b11111;
        end else if (ex_jump_i) begin
          w_flush = 3'b011;
          w_jump  = 1'b1;
          if (C_MULTI_FLUSH) begin
            w_fcnt_nxt  = C_FCNT_LOAD;
            w_state_nxt = ST_FLUSH;
          end
        end else if (ex_muldiv_start_i) begin
          // start with done in the same cycle is a single-cycle op: no stall
          if (!ex_muldiv_done_i) begin
            w_stall     = 5'b00111;
            w_flush     = 3'b100;
            w_state_nxt = ST_MD_WAIT;
          end
        end else if (id_load_hazard_i) begin
          w_stall = 5'b00011;
          w_flush = 3'b010;
        end else if (if_busy_i) begin
          w_stall = 5'b00001;
          w_flush = 3'b001;
        end
      end
      ST_MD_WAIT: begin
        if (mem_busy_i) begin
          w_stall = 5'b11111;
        end else if (ex_muldiv_done_i) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_stall = 5'b00111;
          w_flush = 3'b100;
        end
      end
      ST_FLUSH: begin
        if (mem_busy_i) begin
          w_stall = 5'b11111;
        end else if (ex_jump_i) begin
          w_flush = 3'b011;
          w_jump  = 1'b1;
          if (C_MULTI_FLUSH) begin
            w_fcnt_nxt = C_FCNT_LOAD;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end else begin
          w_flush    = 3'b001;
          w_fcnt_nxt = r_fcnt - 2'd1;
          if (r_fcnt <= 2'd1) begin
            w_state_nxt = ST_RUN;
          end
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_fcnt_nxt  = 2'd0;
      end
    endcase
  end

  // Reset forces every control low combinationally, not just the state
  assign stall_o      = rst ? 5'b00000 : w_stall;
  assign flush_o      = rst ? 3'b000 : w_flush;
  assign jump_o       = rst ? 1'b0 : w_jump;
  assign jump_addr_o  = jump_o ? ex_jump_addr_i : 64'd0;
  assign ctrl_state_o = r_state;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      if (|stall_o) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (|flush_o) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cycles_o = r_stall_cnt;
  assign flush_cycles_o = r_flush_cnt;
`else
  assign stall_cycles_o = 32'd0;
  assign flush_cycles_o = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_pipe_ctrl : directed self-checking bench for pipe_ctrl                 |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        r_hazard;
  logic        r_if_busy;
  logic        r_mem_busy;
  logic        r_jump;
  logic [63:0] r_jump_addr;
  logic        r_md_start;
  logic        r_md_done;

  logic [4:0]  w_stall;
  logic [2:0]  w_flush;
  logic        w_jump;
  logic [63:0] w_jump_addr;
  logic [1:0]  w_state;
  logic [31:0] w_stall_cnt;
  logic [31:0] w_flush_cnt;

  logic [4:0]  w1_stall;
  logic [2:0]  w1_flush;
  logic        w1_jump;
  logic [63:0] w1_jump_addr;
  logic [1:0]  w1_state;
  logic [31:0] w1_stall_cnt;
  logic [31:0] w1_flush_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  pipe_ctrl #(.FLUSH_CYCLES(3)) u_dut (
    .clk(clk), .rst(rst),
    .id_load_hazard_i(r_hazard), .if_busy_i(r_if_busy), .mem_busy_i(r_mem_busy),
    .ex_jump_i(r_jump), .ex_jump_addr_i(r_jump_addr),
    .ex_muldiv_start_i(r_md_start), .ex_muldiv_done_i(r_md_done),
    .stall_o(w_stall), .flush_o(w_flush), .jump_o(w_jump), .jump_addr_o(w_jump_addr),
    .ctrl_state_o(w_state), .stall_cycles_o(w_stall_cnt), .flush_cycles_o(w_flush_cnt)
  );

  pipe_ctrl #(.FLUSH_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .id_load_hazard_i(r_hazard), .if_busy_i(r_if_busy), .mem_busy_i(r_mem_busy),
    .ex_jump_i(r_jump), .ex_jump_addr_i(r_jump_addr),
    .ex_muldiv_start_i(r_md_start), .ex_muldiv_done_i(r_md_done),
    .stall_o(w1_stall), .flush_o(w1_flush), .jump_o(w1_jump), .jump_addr_o(w1_jump_addr),
    .ctrl_state_o(w1_state), .stall_cycles_o(w1_stall_cnt), .flush_cycles_o(w1_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctl(input string tag, input logic [4:0] st, input logic [2:0] fl,
                         input logic [1:0] state);
    chk({tag, ".stall"}, 64'(w_stall), 64'(st));
    chk({tag, ".flush"}, 64'(w_flush), 64'(fl));
    chk({tag, ".state"}, 64'(w_state), 64'(state));
  endtask

  initial begin
    rst         = 1'b1;
    r_hazard    = 1'b1;
    r_if_busy   = 1'b0;
    r_mem_busy  = 1'b0;
    r_jump      = 1'b1;
    r_jump_addr = 64'h0000_0000_8000_0040;
    r_md_start  = 1'b0;
    r_md_done   = 1'b0;

    // outputs must stay quiet under reset even with requests present
    #12;
    chk_ctl("rst", 5'b00000, 3'b000, 2'd0);
    chk("rst.jump", 64'(w_jump), 64'd0);
    chk("rst.jaddr", w_jump_addr, 64'd0);
    chk("rst.scnt", 64'(w_stall_cnt), 64'd0);
    r_hazard = 1'b0;
    r_jump   = 1'b0;
    rst      = 1'b0;

    // load-use: one bubble
    tick();
    r_hazard = 1'b1;
    #2 chk_ctl("lu0", 5'b00011, 3'b010, 2'd0);
    tick();
    r_hazard = 1'b0;
    #2 chk_ctl("lu1", 5'b00000, 3'b000, 2'd0);

    // fetch not ready
    r_if_busy = 1'b1;
    #2 chk_ctl("ifb", 5'b00001, 3'b001, 2'd0);
    tick();
    r_if_busy = 1'b0;

    // DIV: start cycle 0, done cycle 33
    r_md_start = 1'b1;
    #2 chk_ctl("div0", 5'b00111, 3'b100, 2'd0);
    tick();
    r_md_start = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      #2 chk_ctl($sformatf("div%0d", i), 5'b00111, 3'b100, 2'd1);
      tick();
    end
    r_md_done = 1'b1;
    #2 chk_ctl("div33", 5'b00000, 3'b000, 2'd1);
    tick();
    r_md_done = 1'b0;
    #2 chk_ctl("div34", 5'b00000, 3'b000, 2'd0);
    tick();

    // start and done together: no stall, stays in RUN
    r_md_start = 1'b1;
    r_md_done  = 1'b1;
    #2 chk_ctl("mdq", 5'b00000, 3'b000, 2'd0);
    tick();
    r_md_start = 1'b0;
    r_md_done  = 1'b0;
    #2 chk("mdq.state", 64'(w_state), 64'd0);

    // jump, 3-cycle flush (and 1-cycle flush on the second instance)
    r_jump = 1'b1;
    #2 chk_ctl("j0", 5'b00000, 3'b011, 2'd0);
    chk("j0.jump", 64'(w_jump), 64'd1);
    chk("j0.jaddr", w_jump_addr, 64'h0000_0000_8000_0040);
    chk("j0.d1flush", 64'(w1_flush), 64'(3'b011));
    chk("j0.d1jaddr", w1_jump_addr, 64'h0000_0000_8000_0040);
    tick();
    r_jump = 1'b0;
    #2 chk_ctl("j1", 5'b00000, 3'b001, 2'd2);
    chk("j1.jump", 64'(w_jump), 64'd0);
    chk("j1.jaddr", w_jump_addr, 64'd0);
    chk("j1.d1state", 64'(w1_state), 64'd0);
    chk("j1.d1flush", 64'(w1_flush), 64'd0);
    tick();
    #2 chk_ctl("j2", 5'b00000, 3'b001, 2'd2);
    tick();
    #2 chk_ctl("j3", 5'b00000, 3'b000, 2'd0);

    // priority: mem_busy masks jump and hazard for 2 cycles
    r_mem_busy = 1'b1;
    r_jump     = 1'b1;
    r_hazard   = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      #2 chk_ctl($sformatf("pri%0d", i), 5'b11111, 3'b000, 2'd0);
      chk($sformatf("pri%0d.jump", i), 64'(w_jump), 64'd0);
      tick();
    end
    r_mem_busy = 1'b0;
    #2 chk_ctl("pri3", 5'b00000, 3'b011, 2'd0);
    chk("pri3.jump", 64'(w_jump), 64'd1);
    tick();
    r_hazard = 1'b0;
    // second jump while flushing reloads the count
    #2 chk_ctl("rl0", 5'b00000, 3'b011, 2'd2);
    chk("rl0.jump", 64'(w_jump), 64'd1);
    tick();
    r_jump = 1'b0;
    #2 chk_ctl("rl1", 5'b00000, 3'b001, 2'd2);
    tick();
    #2 chk_ctl("rl2", 5'b00000, 3'b001, 2'd2);
    tick();
    #2 chk_ctl("rl3", 5'b00000, 3'b000, 2'd0);

    // MD_WAIT: mem_busy freeze, jump/hazard ignored
    r_md_start = 1'b1;
    tick();
    r_md_start = 1'b0;
    r_mem_busy = 1'b1;
    #2 chk_ctl("mdb", 5'b11111, 3'b000, 2'd1);
    tick();
    r_mem_busy = 1'b0;
    r_jump     = 1'b1;
    r_hazard   = 1'b1;
    #2 chk_ctl("mdj", 5'b00111, 3'b100, 2'd1);
    chk("mdj.jump", 64'(w_jump), 64'd0);
    r_jump    = 1'b0;
    r_hazard  = 1'b0;
    r_md_done = 1'b1;
    #1 chk_ctl("mdd", 5'b00000, 3'b000, 2'd1);
    tick();
    r_md_done = 1'b0;
    #2 chk("mdd.state", 64'(w_state), 64'd0);

    // async reset in MD_WAIT cycle 5
    tick();
    r_md_start = 1'b1;
    tick();
    r_md_start = 1'b0;
    for (int i = 1; i < 5; i++) tick();
    #2 chk("ar.pre", 64'(w_state), 64'd1);
    rst = 1'b1;
    #1 chk_ctl("ar", 5'b00000, 3'b000, 2'd0);
    chk("ar.scnt", 64'(w_stall_cnt), 64'd0);
    chk("ar.fcnt", 64'(w_flush_cnt), 64'd0);
    #1 rst = 1'b0;
    tick();
    #1 chk_ctl("ar.post", 5'b00000, 3'b000, 2'd0);

    // 10-cycle DIV wait for the perf counters
    r_md_start = 1'b1;
    tick();
    r_md_start = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    r_md_done = 1'b1;
    tick();
    r_md_done = 1'b0;
    #2;
`ifdef PIPE_CTRL_PERF_EN
    chk("perf.stall", 64'(w_stall_cnt), 64'd10);
    chk("perf.flush", 64'(w_flush_cnt), 64'd10);
`else
    chk("perf.stall", 64'(w_stall_cnt), 64'd0);
    chk("perf.flush", 64'(w_flush_cnt), 64'd0);
`endif
    chk("perf.state", 64'(w_state), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
